// File: rtl/nolinear_out_serializer.sv
// Serializes a DATA_NUM-element result vector from the nonlinear unit into a valid/ready element stream.
// Define NOLINEAR_OUT_DBL_BUF_EN to add one pending buffer so a vector can arrive while another streams.
module nolinear_out_serializer #(
    parameter int DATA_NUM        = 16,
    parameter int FIX_POINT_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                done,
    input  logic [DATA_NUM*FIX_POINT_WIDTH-1:0] in,
    output logic [FIX_POINT_WIDTH-1:0]          out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(DATA_NUM)-1:0]         out_idx,
    output logic                                out_last,
    output logic                                busy,
    output logic                                overflow
);

    localparam int IDX_W = $clog2(DATA_NUM);
    localparam int VEC_W = DATA_NUM * FIX_POINT_WIDTH;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic [VEC_W-1:0]   active_buf, active_next;
    logic               overflow_next;
    logic               pend_valid;
    logic               xfer;
    logic               at_last;
    logic               last_xfer;

`ifdef NOLINEAR_OUT_DBL_BUF_EN
    logic [VEC_W-1:0]   pend_buf, pend_next;
    logic               pend_valid_next;
`else
    assign pend_valid = 1'b0;
`endif

    assign out_valid = (state == STREAM);
    assign at_last   = (idx == IDX_W'(DATA_NUM - 1));
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && at_last;
    assign out_data  = active_buf[int'(idx) * FIX_POINT_WIDTH +: FIX_POINT_WIDTH];
    assign out_idx   = idx;
    assign out_last  = out_valid && at_last;
    assign busy      = (state == STREAM) || pend_valid;

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        active_next     = active_buf;
        overflow_next   = overflow;
`ifdef NOLINEAR_OUT_DBL_BUF_EN
        pend_next       = pend_buf;
        pend_valid_next = pend_valid;
`endif
        case (state)
            IDLE: begin
                if (done) begin
                    active_next = in;
                    idx_next    = '0;
                    state_next  = STREAM;
                end
            end
            STREAM: begin
                if (xfer && !at_last) begin
                    idx_next = idx + IDX_W'(1);
                end
                // On the final beat a waiting vector always goes before a newly arriving one.
                if (last_xfer) begin
                    idx_next = '0;
`ifdef NOLINEAR_OUT_DBL_BUF_EN
                    if (pend_valid) begin
                        active_next     = pend_buf;
                        pend_valid_next = done;
                        if (done) begin
                            pend_next = in;
                        end
                    end else
`endif
                    if (done) begin
                        active_next = in;
                    end else begin
                        state_next = IDLE;
                    end
                end
                if (done && !last_xfer) begin
`ifdef NOLINEAR_OUT_DBL_BUF_EN
                    if (!pend_valid) begin
                        pend_next       = in;
                        pend_valid_next = 1'b1;
                    end else begin
                        overflow_next = 1'b1;
                    end
`else
                    overflow_next = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            active_buf <= '0;
            overflow   <= 1'b0;
`ifdef NOLINEAR_OUT_DBL_BUF_EN
            pend_buf   <= '0;
            pend_valid <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            active_buf <= active_next;
            overflow   <= overflow_next;
`ifdef NOLINEAR_OUT_DBL_BUF_EN
            pend_buf   <= pend_next;
            pend_valid <= pend_valid_next;
`endif
        end
    end

endmodule

// File: tb/tb_nolinear_out_serializer.sv
// Scoreboard bench for nolinear_out_serializer: a vector-occupancy model predicts accepted/dropped vectors
// and pushes expected beats; a negedge monitor pops and compares every transfer.
module tb_nolinear_out_serializer;

    localparam int N   = 16;
    localparam int W   = 16;
    localparam int VW  = N * W;
`ifdef NOLINEAR_OUT_DBL_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   idx;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          done = 1'b0;
    logic [VW-1:0] inVec = '0;
    logic [W-1:0]  outData;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [3:0]    outIdx;
    logic          outLast;
    logic          busy;
    logic          overflow;

    beat_t sb[$];
    int    modelBeats    = 0;
    bit    modelOverflow = 1'b0;
    int    tests = 0;
    int    fails = 0;

    nolinear_out_serializer #(.DATA_NUM(N), .FIX_POINT_WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .done(done),
        .in(inVec),
        .out_data(outData),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_idx(outIdx),
        .out_last(outLast),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [VW-1:0] makeRamp();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(16'h0100 * k);
        return v;
    endfunction

    function automatic logic [VW-1:0] makeRandom();
        logic [VW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
        return v;
    endfunction

    // One clock: drive inputs, then update the model from what was sampled at the edge.
    // A vector is accepted if, after this edge's transfer, fewer than CAP vectors remain held.
    task automatic applyStimulus(input bit d, input logic [VW-1:0] v, input bit r);
        beat_t b;
        done = d;
        inVec = v;
        outReady = r;
        @(posedge clk);
        if (modelBeats > 0 && r) modelBeats--;
        if (d) begin
            if ((modelBeats + N - 1) / N < CAP) begin
                for (int k = 0; k < N; k++) begin
                    b.data = v[k*W +: W];
                    b.idx  = 4'(k);
                    b.last = (k == N - 1);
                    sb.push_back(b);
                end
                modelBeats += N;
            end else begin
                modelOverflow = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && modelBeats > 0; c++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("drain_busy", 32'(busy), 32'd0);
        checkOutput("drain_valid", 32'(outValid), 32'd0);
    endtask

    always @(negedge clk) begin
        beat_t e;
        checkOutput("out_valid", 32'(outValid), 32'(modelBeats > 0));
        checkOutput("busy", 32'(busy), 32'(modelBeats > 0));
        checkOutput("overflow", 32'(overflow), 32'(modelOverflow));
        if (outValid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_beat: got idx %0d data %0h, expected no beat", outIdx, outData);
            end else begin
                e = sb[0];
                checkOutput("out_data", 32'(outData), 32'(e.data));
                checkOutput("out_idx", 32'(outIdx), 32'(e.idx));
                checkOutput("out_last", 32'(outLast), 32'(e.last));
                if (outReady) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [VW-1:0] vecA, vecB, vecC;

        #2 rst = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(outValid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_data", 32'(outData), 32'd0);
        checkOutput("reset_idx", 32'(outIdx), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Ramp vector streamed with ready held high
        applyStimulus(1'b1, makeRamp(), 1'b1);
        drain();

        // Backpressure pattern 1,0,0,1 repeating
        applyStimulus(1'b1, makeRandom(), 1'b1);
        for (int c = 0; c < 64; c++) applyStimulus(1'b0, '0, (c % 4 == 0) || (c % 4 == 3));
        drain();

        // Second done coincident with the final beat of the first vector
        applyStimulus(1'b1, makeRandom(), 1'b1);
        for (int c = 0; c < 15; c++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, makeRandom(), 1'b1);
        drain();
        checkOutput("coincident_overflow", 32'(overflow), 32'd0);

        // Dones at beat 5 and beat 6 of a stream
        vecA = makeRandom();
        vecB = makeRandom();
        vecC = makeRandom();
        applyStimulus(1'b1, vecA, 1'b1);
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, vecB, 1'b1);
        checkOutput("beat5_overflow", 32'(overflow), 32'(CAP == 1));
        applyStimulus(1'b1, vecC, 1'b1);
        checkOutput("beat6_overflow", 32'(overflow), 32'd1);
        drain();

        // Reset asserted mid-stream at beat 8, checked before any clock edge
        applyStimulus(1'b1, makeRamp(), 1'b1);
        for (int c = 0; c < 8; c++) applyStimulus(1'b0, '0, 1'b1);
        #2 rst = 1'b0;
        sb.delete();
        modelBeats = 0;
        modelOverflow = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(outValid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_overflow", 32'(overflow), 32'd0);
        checkOutput("midrst_last", 32'(outLast), 32'd0);
        checkOutput("midrst_idx", 32'(outIdx), 32'd0);
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, makeRamp(), 1'b1);
        drain();
        checkOutput("postrst_overflow", 32'(overflow), 32'd0);

        // Randomized traffic
        for (int c = 0; c < 400; c++)
            applyStimulus($urandom_range(0, 5) == 0, makeRandom(), $urandom_range(0, 9) < 7);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
